fifo_stream_drain: RTL and testbench

FIFO_STREAM_DRAIN -- requirements
Module: fifo_stream_drain

---
 rtl/fifo_stream_drain.sv | 82 ++++++++
 tb/tb_fifo_stream_drain.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_drain.sv
// Drains an async FIFO's read side into a valid/ready stream, framing beats into
// fixed-length packets and counting completed packets.
module fifo_stream_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int PKT_LEN    = 8
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [15:0]           pkt_count
);

  localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

  logic [DATA_WIDTH-1:0] buf_q [3];
  logic [1:0]  head_q, head_d, count_q, count_d, tail;
  logic        inflight_q;
  logic [15:0] beat_q, beat_d, pkt_q, pkt_d;
  logic [2:0]  occ;
  logic        push, pop;

  // Ring index arithmetic over the 3 buffer slots; inputs never sum past 5.
  function automatic logic [1:0] wrap_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Credit check counts the word already in flight so the buffer can never overrun.
  assign occ        = {1'b0, count_q} + {2'b00, inflight_q};
  assign fifo_rd_en = !rd_rst && !fifo_empty && (occ < 3'd3);

  assign m_valid   = !rd_rst && (count_q != 2'd0);
  assign m_data    = m_valid ? buf_q[head_q] : '0;
  assign m_last    = m_valid && (beat_q == LAST_BEAT);
  assign pkt_count = pkt_q;

  assign push = inflight_q;
  assign pop  = m_valid && m_ready;
  assign tail = wrap_add(head_q, count_q);

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (!push && pop) count_d = count_q - 2'd1;
    head_d = pop ? wrap_add(head_q, 2'd1) : head_q;
    beat_d = beat_q;
    pkt_d  = pkt_q;
    if (pop) begin
      beat_d = m_last ? 16'd0 : beat_q + 16'd1;
      if (m_last) pkt_d = pkt_q + 16'd1;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      count_q    <= 2'd0;
      head_q     <= 2'd0;
      inflight_q <= 1'b0;
      beat_q     <= 16'd0;
      pkt_q      <= 16'd0;
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      inflight_q <= fifo_rd_en;
      beat_q     <= beat_d;
      pkt_q      <= pkt_d;
    end
  end

  // Payload storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge rd_clk) begin
    if (push) buf_q[tail] <= fifo_rd_data;
  end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Directed bench for fifo_stream_drain: three instances (PKT_LEN 8, 5, 1) fed by
// queue-based FIFO models with an in-order scoreboard on each stream.
module tb_fifo_stream_drain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instance A: PKT_LEN=8
  logic        rst_a, empty_a, rd_en_a, valid_a, ready_a, last_a;
  logic [31:0] rd_data_a, data_a;
  logic [15:0] pkt_a;
  logic [31:0] qa[$], ea[$];
  bit          gap_a = 1'b0;
  int          beat_a = 0;

  assign empty_a = gap_a || (qa.size() == 0);
  always @(posedge clk) if (rd_en_a) rd_data_a <= qa.pop_front();

  fifo_stream_drain #(.DATA_WIDTH(32), .PKT_LEN(8)) dut_a (
    .rd_clk(clk), .rd_rst(rst_a), .fifo_empty(empty_a), .fifo_rd_en(rd_en_a),
    .fifo_rd_data(rd_data_a), .m_valid(valid_a), .m_ready(ready_a),
    .m_data(data_a), .m_last(last_a), .pkt_count(pkt_a));

  always @(negedge clk) begin
    logic [31:0] exp;
    if (rst_a) beat_a = 0;
    else if (valid_a && ready_a) begin
      exp = (ea.size() != 0) ? ea.pop_front() : 32'hDEADBEEF;
      chk("a_data", data_a, exp);
      chk("a_last", 32'(last_a), 32'(beat_a == 7));
      beat_a = (beat_a + 1) % 8;
    end
  end

  // Instance B: PKT_LEN=5, random gaps and backpressure
  logic        rst_b, empty_b, rd_en_b, valid_b, ready_b, last_b;
  logic [31:0] rd_data_b, data_b;
  logic [15:0] pkt_b;
  logic [31:0] qb[$], eb[$];
  bit          gap_b = 1'b0;
  int          beat_b = 0;
  int          nb_b = 0;

  assign empty_b = gap_b || (qb.size() == 0);
  always @(posedge clk) if (rd_en_b) rd_data_b <= qb.pop_front();

  fifo_stream_drain #(.DATA_WIDTH(32), .PKT_LEN(5)) dut_b (
    .rd_clk(clk), .rd_rst(rst_b), .fifo_empty(empty_b), .fifo_rd_en(rd_en_b),
    .fifo_rd_data(rd_data_b), .m_valid(valid_b), .m_ready(ready_b),
    .m_data(data_b), .m_last(last_b), .pkt_count(pkt_b));

  always @(negedge clk) begin
    logic [31:0] exp;
    if (rst_b) beat_b = 0;
    else if (valid_b && ready_b) begin
      exp = (eb.size() != 0) ? eb.pop_front() : 32'hDEADBEEF;
      chk("b_data", data_b, exp);
      chk("b_last", 32'(last_b), 32'(beat_b == 4));
      beat_b = (beat_b + 1) % 5;
      nb_b++;
    end
  end

  // Instance C: PKT_LEN=1, free-running for the packet counter wrap
  logic        rst_c, empty_c, rd_en_c, valid_c, ready_c, last_c;
  logic [31:0] rd_data_c, data_c;
  logic [15:0] pkt_c;

  fifo_stream_drain #(.DATA_WIDTH(32), .PKT_LEN(1)) dut_c (
    .rd_clk(clk), .rd_rst(rst_c), .fifo_empty(empty_c), .fifo_rd_en(rd_en_c),
    .fifo_rd_data(rd_data_c), .m_valid(valid_c), .m_ready(ready_c),
    .m_data(data_c), .m_last(last_c), .pkt_count(pkt_c));

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt;
    int rdn;
    int cyc;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0;
    empty_c = 1'b1; rd_data_c = 32'h000000A5;
    for (int i = 1; i <= 16; i++) begin qa.push_back(32'(i)); ea.push_back(32'(i)); end

    // Reset state with a nonempty FIFO
    step();
    @(negedge clk);
    chk("rst_rden", 32'(rd_en_a), 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_last", 32'(last_a), 32'd0);
    chk("rst_data", data_a, 32'd0);
    chk("rst_pkt", 32'(pkt_a), 32'd0);
    step();

    // Stream 0x01..0x10
    rst_a = 1'b0; ready_a = 1'b1;
    @(negedge clk);
    chk("s_rden_c0", 32'(rd_en_a), 32'd1);
    chk("s_valid_c0", 32'(valid_a), 32'd0);
    step(); @(negedge clk);
    chk("s_valid_c1", 32'(valid_a), 32'd0);
    step(); @(negedge clk);
    chk("s_valid_c2", 32'(valid_a), 32'd1);
    vcnt = 1;
    for (int i = 0; i < 15; i++) begin
      step(); @(negedge clk);
      if (valid_a) vcnt++;
    end
    chk("s_b2b", 32'(vcnt), 32'd16);
    step(); @(negedge clk);
    chk("s_valid_end", 32'(valid_a), 32'd0);
    chk("s_drained", 32'(ea.size()), 32'd0);
    chk("s_pkt", 32'(pkt_a), 32'd2);

    // Empty FIFO throughout
    for (int i = 0; i < 10; i++) begin
      step(); @(negedge clk);
      chk("e_rden", 32'(rd_en_a), 32'd0);
      chk("e_valid", 32'(valid_a), 32'd0);
    end

    // Backpressure: m_ready low for 10 cycles
    step();
    ready_a = 1'b0;
    for (int i = 0; i < 16; i++) begin qa.push_back(32'h20 + 32'(i)); ea.push_back(32'h20 + 32'(i)); end
    rdn = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_en_a) rdn++;
      if (valid_a) chk("bp_hold", data_a, 32'h20);
      step();
    end
    @(negedge clk);
    chk("bp_reads", 32'(rdn), 32'd3);
    chk("bp_rden", 32'(rd_en_a), 32'd0);
    chk("bp_valid", 32'(valid_a), 32'd1);
    chk("bp_data", data_a, 32'h20);
    chk("bp_last", 32'(last_a), 32'd0);
    step();
    ready_a = 1'b1;
    for (int i = 0; i < 60 && ea.size() != 0; i++) step();
    step(); @(negedge clk);
    chk("bp_drained", 32'(ea.size()), 32'd0);
    chk("bp_pkt", 32'(pkt_a), 32'd4);

    // Reset mid-stream with count=2, inflight=1
    step();
    ready_a = 1'b0;
    for (int i = 0; i < 8; i++) begin qa.push_back(32'h40 + 32'(i)); ea.push_back(32'h40 + 32'(i)); end
    step(); step(); @(negedge clk);
    chk("r_pre_valid", 32'(valid_a), 32'd1);
    chk("r_pre_data", data_a, 32'h40);
    step();
    rst_a = 1'b1; qa.delete(); ea.delete();
    @(negedge clk);
    chk("r_rden", 32'(rd_en_a), 32'd0);
    chk("r_valid_in", 32'(valid_a), 32'd0);
    step();
    rst_a = 1'b0;
    @(negedge clk);
    chk("r_valid", 32'(valid_a), 32'd0);
    chk("r_data", data_a, 32'd0);
    chk("r_last", 32'(last_a), 32'd0);
    chk("r_pkt", 32'(pkt_a), 32'd0);
    step();
    ready_a = 1'b1;
    for (int i = 0; i < 8; i++) begin qa.push_back(32'h50 + 32'(i)); ea.push_back(32'h50 + 32'(i)); end
    for (int i = 0; i < 40 && ea.size() != 0; i++) step();
    step(); @(negedge clk);
    chk("r_post_drained", 32'(ea.size()), 32'd0);
    chk("r_post_pkt", 32'(pkt_a), 32'd1);

    // Random gaps and backpressure, PKT_LEN=5
    step();
    rst_b = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] w;
      w = $urandom;
      qb.push_back(w); eb.push_back(w);
    end
    cyc = 0;
    while (eb.size() != 0 && cyc < 8000) begin
      gap_b = ($urandom_range(0, 3) == 0);
      ready_b = ($urandom_range(0, 3) != 0);
      step();
      cyc++;
    end
    gap_b = 1'b0; ready_b = 1'b1;
    step(); @(negedge clk);
    chk("rnd_drained", 32'(eb.size()), 32'd0);
    chk("rnd_beats", 32'(nb_b), 32'd1000);
    chk("rnd_pkt", 32'(pkt_b), 32'd200);

    // Packet counter wrap, PKT_LEN=1
    step();
    rst_c = 1'b0; empty_c = 1'b0; ready_c = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("w_valid", 32'(valid_c), 32'd1);
    chk("w_last", 32'(last_c), 32'd1);
    chk("w_pkt1", 32'(pkt_c), 32'd1);
    repeat (65534) @(posedge clk);
    @(negedge clk);
    chk("w_pkt_max", 32'(pkt_c), 32'hFFFF);
    @(posedge clk);
    @(negedge clk);
    chk("w_pkt_wrap", 32'(pkt_c), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
